i2c_led_driver: RTL and testbench

- Four-channel LED controller, programmed over an I2C slave port (SCL input, open-drain SDA).
- Eight 8-bit registers select per-LED mode, individual PWM duty, and group dimming or group blinking. Sleep and output inversion are also supported.
- Sits between the board I2C bus and the LED pins. All logic runs in one system clock domain; SCL and SDA are oversampled.

---
 rtl/i2c_led_driver.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_led_driver.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_led_driver.sv
// Four-channel I2C-programmed LED driver: register file, I2C slave,
// individual PWM, group dimming/blinking, sleep and output inversion.
`timescale 1ns/1ps
module i2c_led_driver #(
    parameter logic [6:0] SLAVE_ADDR = 7'h62,
    parameter int         PWM_DIV    = 16,
    parameter int         BLINK_DIV  = 4069
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [3:0] leds
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REG,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    localparam logic [15:0] PWM_LAST   = 16'(PWM_DIV - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

    logic [1:0] r_scl_s;
    logic [1:0] r_sda_s;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;

    state_t      r_state;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic [7:0]  r_ptr;
    logic        r_rw;
    logic        r_sda_oe;
    logic [7:0]  r_regs [8];

    logic [7:0]  w_byte;
    logic [7:0]  w_ptr_next;
    logic [7:0]  w_rd_data;

    logic [15:0] r_pwm_div;
    logic [15:0] r_blink_div;
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_grp_cnt;
    logic [7:0]  r_blink_pre;
    logic [7:0]  r_blink_cnt;
    logic [3:0]  r_leds;

    logic        w_sleep;
    logic        w_dmblnk;
    logic        w_invrt;
    logic        w_pwm_tick;
    logic        w_blink_tick;
    logic        w_grp;
    logic [3:0]  w_pwm;
    logic [3:0]  w_int;

    assign sda  = r_sda_oe ? 1'b0 : 1'bz;
    assign leds = r_leds;

    assign w_scl      = r_scl_s[1];
    assign w_sda      = r_sda_s[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_ptr_next = (r_ptr == 8'h07) ? 8'h00 : r_ptr + 8'h01;
    assign w_rd_data  = (r_ptr < 8'd8) ? r_regs[r_ptr[2:0]] : 8'h00;

    assign w_sleep  = r_regs[0][4];
    assign w_dmblnk = r_regs[0][3];
    assign w_invrt  = r_regs[0][2];

    assign w_pwm_tick   = (r_pwm_div == PWM_LAST);
    assign w_blink_tick = (r_blink_div == BLINK_LAST);

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_s <= 2'b11;
            r_sda_s <= 2'b11;
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], scl};
            r_sda_s <= {r_sda_s[0], sda};
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // I2C slave FSM: byte reception, ACK drive, read shift-out, reg writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'h00;
            r_tx     <= 8'h00;
            r_ptr    <= 8'h00;
            r_rw     <= 1'b0;
            r_sda_oe <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_start) begin
            r_state  <= S_ADDR;
            r_bitcnt <= 4'd0;
            r_sda_oe <= 1'b0;
        end else if (w_stop) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_sda_oe <= 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise && r_bitcnt < 4'd8) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7 && r_state == S_REG) begin
                            r_ptr <= w_byte;
                        end
                        if (r_bitcnt == 4'd7 && r_state == S_WDATA) begin
                            if (r_ptr < 8'd8) begin
                                r_regs[r_ptr[2:0]] <= w_byte;
                            end
                            r_ptr <= w_ptr_next;
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        if (r_state == S_ADDR &&
                            r_shift[7:1] != SLAVE_ADDR) begin
                            r_state  <= S_IGNORE;
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_sda_oe <= 1'b1;
                            r_bitcnt <= 4'd9;
                            r_rw     <= r_shift[0];
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                        r_bitcnt <= 4'd0;
                        if (r_state == S_ADDR && r_rw) begin
                            r_state  <= S_RDATA;
                            r_tx     <= w_rd_data;
                            r_sda_oe <= ~w_rd_data[7];
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= (r_state == S_ADDR) ? S_REG : S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && r_bitcnt < 4'd8) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_rise && r_bitcnt == 4'd8) begin
                        if (!w_sda) begin
                            r_ptr    <= w_ptr_next;
                            r_bitcnt <= 4'd9;
                        end else begin
                            r_state  <= S_IGNORE;
                            r_bitcnt <= 4'd0;
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        r_sda_oe <= 1'b0;
                    end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                        r_tx     <= w_rd_data;
                        r_sda_oe <= ~w_rd_data[7];
                        r_bitcnt <= 4'd0;
                    end else if (w_scl_fall && r_bitcnt != 4'd0) begin
                        r_tx     <= {r_tx[6:0], 1'b0};
                        r_sda_oe <= ~r_tx[6];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // PWM, group-dim and blink counters; frozen while sleeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwm_div   <= 16'd0;
            r_blink_div <= 16'd0;
            r_pwm_cnt   <= 8'h00;
            r_grp_cnt   <= 8'h00;
            r_blink_pre <= 8'h00;
            r_blink_cnt <= 8'h00;
        end else if (!w_sleep) begin
            r_pwm_div <= w_pwm_tick ? 16'd0 : r_pwm_div + 16'd1;
            if (w_pwm_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                if (r_pwm_cnt == 8'hFF) begin
                    r_grp_cnt <= r_grp_cnt + 8'd1;
                end
            end
            r_blink_div <= w_blink_tick ? 16'd0 : r_blink_div + 16'd1;
            if (w_blink_tick) begin
                if (r_blink_pre >= r_regs[6]) begin
                    r_blink_pre <= 8'h00;
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end else begin
                    r_blink_pre <= r_blink_pre + 8'd1;
                end
            end
        end
    end

    // Per-LED internal value selected by the LEDOUT field
    always_comb begin
        w_pwm = 4'h0;
        w_int = 4'h0;
        w_grp = w_dmblnk ? (r_blink_cnt < r_regs[5]) : (r_grp_cnt < r_regs[5]);
        for (int i = 0; i < 4; i++) begin
            w_pwm[i] = (r_pwm_cnt < r_regs[i + 1]);
            unique case (r_regs[7][2*i +: 2])
                2'b00: w_int[i] = 1'b0;
                2'b01: w_int[i] = 1'b1;
                2'b10: w_int[i] = w_pwm[i];
                2'b11: w_int[i] = w_pwm[i] & w_grp;
            endcase
        end
    end

    // Registered LED outputs with sleep blanking and inversion
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_leds <= 4'h0;
        end else begin
            r_leds <= w_sleep ? 4'h0 : (w_int ^ {4{w_invrt}});
        end
    end

endmodule

// File: tb/tb_i2c_led_driver.sv
// Directed bench for i2c_led_driver: bit-banged I2C master,
// duty-cycle counting on the LED outputs.
`timescale 1ns/1ps
module tb_i2c_led_driver;

    localparam logic [6:0] ADDR = 7'h62;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [3:0] leds;
    wire        sda;

    int vec = 0;
    int errs = 0;
    int cnt [4];

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_led_driver #(
        .SLAVE_ADDR(ADDR),
        .PWM_DIV(1),
        .BLINK_DIV(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .scl(m_scl),
        .sda(sda),
        .leds(leds)
    );

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_oe = 1'b0;
        wclk(4);
        m_scl = 1'b1;
        wclk(4);
        m_sda_oe = 1'b1;
        wclk(4);
        m_scl = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1;
        wclk(4);
        m_scl = 1'b1;
        wclk(4);
        m_sda_oe = 1'b0;
        wclk(8);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_oe = ~b[i];
            wclk(4);
            m_scl = 1'b1;
            wclk(8);
            m_scl = 1'b0;
            wclk(4);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        m_sda_oe = 1'b0;
        wclk(4);
        m_scl = 1'b1;
        wclk(4);
        ack = (sda === 1'b0);
        wclk(4);
        m_scl = 1'b0;
        wclk(4);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic [7:0] t;
        t = 8'h00;
        m_sda_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wclk(4);
            m_scl = 1'b1;
            wclk(4);
            t = {t[6:0], (sda === 1'b1)};
            wclk(4);
            m_scl = 1'b0;
        end
        wclk(4);
        m_sda_oe = mack;
        wclk(4);
        m_scl = 1'b1;
        wclk(8);
        m_scl = 1'b0;
        wclk(4);
        d = t;
    endtask

    task automatic reg_write(input logic [6:0] a, input logic [7:0] ptr,
                             input int n, input logic [31:0] data,
                             output logic ack);
        logic ak;
        i2c_start();
        wr_byte({a, 1'b0}, ak);
        ack = ak;
        if (ak) begin
            wr_byte(ptr, ak);
            ack &= ak;
            for (int i = 0; i < n; i++) begin
                wr_byte(data[8*i +: 8], ak);
                ack &= ak;
            end
        end
        i2c_stop();
        wclk(4);
    endtask

    task automatic reg_read(input logic [7:0] ptr, input int n,
                            output logic [31:0] data, output logic ack);
        logic       ak;
        logic [7:0] d;
        data = 32'h0;
        i2c_start();
        wr_byte({ADDR, 1'b0}, ak);
        ack = ak;
        wr_byte(ptr, ak);
        ack &= ak;
        i2c_start();
        wr_byte({ADDR, 1'b1}, ak);
        ack &= ak;
        for (int i = 0; i < n; i++) begin
            rd_byte(i != n - 1, d);
            data[8*i +: 8] = d;
        end
        i2c_stop();
        wclk(4);
    endtask

    task automatic measure(input int n);
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (leds[j]) cnt[j]++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wclk(5);
        reset_n = 1'b1;
        wclk(2);
        vec++;
        if (leds !== 4'h0) begin
            errs++;
            $display("FAIL reset_leds: got %h expected 0", leds);
        end
        vec++;
        if (sda !== 1'b1) begin
            errs++;
            $display("FAIL reset_sda: got %b expected 1", sda);
        end
    endtask

    task automatic test_static();
        logic        ack;
        logic [31:0] d;
        reg_write(ADDR, 8'h07, 1, 32'h55, ack);
        vec++;
        if (ack !== 1'b1) begin
            errs++;
            $display("FAIL static_ack: got %b expected 1", ack);
        end
        vec++;
        if (leds !== 4'hF) begin
            errs++;
            $display("FAIL static_leds: got %h expected f", leds);
        end
        reg_read(8'h00, 1, d, ack);
        vec++;
        if (ack !== 1'b1 || d[7:0] !== 8'h00) begin
            errs++;
            $display("FAIL mode_read: got %h ack %b expected 00 ack 1",
                     d[7:0], ack);
        end
    endtask

    task automatic test_pwm();
        logic ack;
        reg_write(ADDR, 8'h01, 4, 32'hFFC08040, ack);
        reg_write(ADDR, 8'h07, 1, 32'hAA, ack);
        measure(256);
        vec++;
        if (cnt[0] !== 64 || cnt[1] !== 128 ||
            cnt[2] !== 192 || cnt[3] !== 255) begin
            errs++;
            $display("FAIL pwm_duty: got %0d/%0d/%0d/%0d expected 64/128/192/255",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        reg_write(ADDR, 8'h02, 1, 32'h01, ack);
        measure(256);
        vec++;
        if (cnt[1] !== 1) begin
            errs++;
            $display("FAIL pwm_min: got %0d expected 1", cnt[1]);
        end
    endtask

    task automatic test_readback();
        logic        ack;
        logic [31:0] d;
        reg_read(8'h01, 4, d, ack);
        vec++;
        if (ack !== 1'b1 || d !== 32'hFFC00140) begin
            errs++;
            $display("FAIL pwm_readback: got %h ack %b expected ffc00140",
                     d, ack);
        end
        reg_read(8'h07, 2, d, ack);
        vec++;
        if (d !== 32'h000000AA) begin
            errs++;
            $display("FAIL read_wrap: got %h expected 000000aa", d);
        end
        reg_read(8'h0A, 1, d, ack);
        vec++;
        if (ack !== 1'b1 || d !== 32'h0) begin
            errs++;
            $display("FAIL read_oob: got %h ack %b expected 0 ack 1", d, ack);
        end
    endtask

    task automatic test_group_dim();
        logic ack;
        reg_write(ADDR, 8'h01, 1, 32'hFF, ack);
        reg_write(ADDR, 8'h05, 3, 32'h00FF00C0, ack);
        measure(65536);
        vec++;
        if (cnt[0] !== 48960) begin
            errs++;
            $display("FAIL grp_dim0: got %0d expected 48960", cnt[0]);
        end
        vec++;
        if (cnt[1] !== 192) begin
            errs++;
            $display("FAIL grp_dim1: got %0d expected 192", cnt[1]);
        end
        reg_write(ADDR, 8'h05, 1, 32'h00, ack);
        measure(256);
        vec++;
        if (cnt[0] + cnt[1] + cnt[2] + cnt[3] !== 0) begin
            errs++;
            $display("FAIL grp_off: got %0d expected 0",
                     cnt[0] + cnt[1] + cnt[2] + cnt[3]);
        end
    endtask

    task automatic test_blink();
        logic ack;
        reg_write(ADDR, 8'h01, 4, 32'hFFFFFFFF, ack);
        reg_write(ADDR, 8'h05, 2, 32'h0380, ack);
        reg_write(ADDR, 8'h00, 1, 32'h08, ack);
        wclk(1024);
        measure(1024);
        vec++;
        if (cnt[0] !== 510 || cnt[3] !== 510) begin
            errs++;
            $display("FAIL blink_f3: got %0d/%0d expected 510/510",
                     cnt[0], cnt[3]);
        end
        reg_write(ADDR, 8'h06, 1, 32'h01, ack);
        wclk(512);
        measure(512);
        vec++;
        if (cnt[0] !== 255 || cnt[2] !== 255) begin
            errs++;
            $display("FAIL blink_f1: got %0d/%0d expected 255/255",
                     cnt[0], cnt[2]);
        end
    endtask

    task automatic test_sleep_invert();
        logic        ack;
        logic [31:0] d;
        reg_write(ADDR, 8'h07, 1, 32'h55, ack);
        reg_write(ADDR, 8'h00, 1, 32'h10, ack);
        measure(32);
        vec++;
        if (cnt[0] + cnt[1] + cnt[2] + cnt[3] !== 0) begin
            errs++;
            $display("FAIL sleep_leds: got %0d expected 0",
                     cnt[0] + cnt[1] + cnt[2] + cnt[3]);
        end
        reg_read(8'h00, 1, d, ack);
        vec++;
        if (d[7:0] !== 8'h10) begin
            errs++;
            $display("FAIL sleep_read: got %h expected 10", d[7:0]);
        end
        reg_write(ADDR, 8'h07, 2, 32'h0400, ack);
        vec++;
        if (leds !== 4'hF) begin
            errs++;
            $display("FAIL invert_leds: got %h expected f", leds);
        end
        reg_read(8'h00, 1, d, ack);
        vec++;
        if (d[7:0] !== 8'h04) begin
            errs++;
            $display("FAIL write_wrap: got %h expected 04", d[7:0]);
        end
    endtask

    task automatic test_wrong_addr();
        logic        ack;
        logic [31:0] d;
        reg_write(7'h63, 8'h07, 1, 32'h55, ack);
        vec++;
        if (ack !== 1'b0) begin
            errs++;
            $display("FAIL wrong_addr_nack: got %b expected 0", ack);
        end
        reg_read(8'h07, 1, d, ack);
        vec++;
        if (d[7:0] !== 8'h00 || leds !== 4'hF) begin
            errs++;
            $display("FAIL wrong_addr_regs: got %h leds %h expected 00 leds f",
                     d[7:0], leds);
        end
    endtask

    task automatic test_reset_mid();
        logic        ack;
        logic [31:0] d;
        i2c_start();
        send_bits({ADDR, 1'b0});
        m_sda_oe = 1'b0;
        wclk(1);
        vec++;
        if (sda !== 1'b0) begin
            errs++;
            $display("FAIL mid_ack_held: got %b expected 0", sda);
        end
        reset_n = 1'b0;
        wclk(1);
        vec++;
        if (sda !== 1'b1) begin
            errs++;
            $display("FAIL mid_release: got %b expected 1", sda);
        end
        i2c_stop();
        reset_n = 1'b1;
        wclk(4);
        vec++;
        if (leds !== 4'h0) begin
            errs++;
            $display("FAIL mid_leds: got %h expected 0", leds);
        end
        reg_read(8'h00, 2, d, ack);
        vec++;
        if (ack !== 1'b1 || d !== 32'h0) begin
            errs++;
            $display("FAIL mid_regs: got %h ack %b expected 0 ack 1", d, ack);
        end
        reg_read(8'h07, 1, d, ack);
        vec++;
        if (d !== 32'h0) begin
            errs++;
            $display("FAIL mid_ledout: got %h expected 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm();
        test_readback();
        test_group_dim();
        test_blink();
        test_sleep_invert();
        test_wrong_addr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
